// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: data width, register-file geometry and
// small enums used by the register-file write-back path.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Which requester won the most recent round-robin transfer.
  typedef enum logic {
    RR_LAST_A = 1'b0,
    RR_LAST_B = 1'b1
  } rr_last_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant from valid requests; on a tie
// the requester that did not win last is granted. Pointer moves on grant_taken.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_taken,
  output logic [1:0] grant
);

  rr_last_e last_q;
  rr_last_e last_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_q == RR_LAST_B) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_taken && grant[0]) begin
      last_d = RR_LAST_A;
    end else if (grant_taken && grant[1]) begin
      last_d = RR_LAST_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= RR_LAST_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU (A) and load (B) writes
// onto one registered write port and tracks outstanding writes for decode.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = riscv_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic            we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd
);

  logic [1:0]          grant;
  logic                xfer;
  riscv_pkg::reg_addr_t win_rd;
  logic [XLEN-1:0]     win_wd;

  logic                we_q, we_d;
  riscv_pkg::reg_addr_t rd_q, rd_d;
  logic [XLEN-1:0]     wd_q, wd_d;
  logic [NREG-1:0]     busy_q, busy_d;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({b_valid, a_valid}),
    .grant_taken (xfer),
    .grant       (grant)
  );

  // Readies are forced low while reset is held so nothing is accepted then.
  assign a_ready = grant[0] & rst_n;
  assign b_ready = grant[1] & rst_n;
  assign xfer    = a_ready | b_ready;

  always_comb begin
    win_rd = grant[1] ? b_rd : a_rd;
    win_wd = grant[1] ? b_wd : a_wd;
  end

  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (xfer) begin
      we_d = (win_rd != '0);
      rd_d = win_rd;
      wd_d = win_wd;
    end
  end

  // Clear applies first so a same-edge issue to that register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    stall = busy_q[rs1] | busy_q[rs2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign we = we_q;
  assign rd = rd_q;
  assign wd = wd_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, write port and scoreboard.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2, rd;
  logic [31:0] a_wd, b_wd, wd;
  logic        iss_valid, stall, we;

  int checks;
  int errors;

  // Model state: set of registers with a pending write, who won last, and the
  // write that the register file will see next cycle.
  bit [31:0] mbusy;
  bit        mlast_b;
  bit        mwe;
  bit [4:0]  mrd;
  bit [31:0] mwd;

  regfile_wb_ctrl #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wd(b_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .we(we), .rd(rd), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_grant(output bit ga, output bit gb);
    // Alone wins; in a tie the one that did not win last time wins.
    ga = a_valid && (!b_valid || mlast_b);
    gb = b_valid && (!a_valid || !mlast_b);
  endfunction

  function automatic bit exp_stall();
    return (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]);
  endfunction

  task automatic model_reset();
    mbusy = '0; mlast_b = 1'b1; mwe = 1'b0; mrd = '0; mwd = '0;
  endtask

  // Advance one clock and move the model by one transaction step.
  task automatic tick();
    bit ga, gb;
    model_grant(ga, gb);
    @(posedge clk);
    if (iss_valid && iss_rd != 0) begin
      checks++;
      if (mbusy[iss_rd]) begin
        errors++;
        $display("FAIL waw_issue: issue to rd=%0d while already outstanding", iss_rd);
      end
    end
    if (mwe) mbusy[mrd] = 1'b0;
    if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    if (ga || gb) begin
      mrd = ga ? a_rd : b_rd;
      mwd = ga ? a_wd : b_wd;
      mwe = (mrd != 0);
      mlast_b = gb;
    end else begin
      mwe = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; iss_valid = 0;
    a_rd = 0; b_rd = 0; a_wd = 0; b_wd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; a_valid = 1; b_valid = 1;
    #3;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", rd); end
    checks++; if (wd !== 32'd0) begin errors++; $display("FAIL rst_wd: got %h want 0", wd); end
    @(negedge clk); rst_n = 1; a_valid = 0; b_valid = 0;
    model_reset();
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b%b want 00", a_ready, b_ready); end
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(31 - r); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall r%0d: got %b want 0", r, stall); end
    end
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_a_only();
    a_valid = 1; a_rd = 5; a_wd = 32'hDEADBEEF; #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL a_only_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    tick();
    a_valid = 0; #1;
    checks++; if (we !== 1'b1 || rd !== 5'd5 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_port: got we=%b rd=%0d wd=%h want 1/5/deadbeef", we, rd, wd); end
    tick();
    checks++; if (we !== 1'b0 || rd !== 5'd5) begin errors++; $display("FAIL a_only_idle: got we=%b rd=%0d want we=0 rd=5", we, rd); end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; b_valid = 1; a_rd = 1; b_rd = 2;
      a_wd = $urandom; b_wd = $urandom; #1;
      checks++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL contention_grant%0d: got a=%b b=%b want a=%b", i, a_ready, b_ready, (i % 2 == 0));
      end
      if (i > 0) begin
        checks++;
        if (we !== 1'b1 || rd !== ((i % 2 == 1) ? 5'd1 : 5'd2)) begin
          errors++; $display("FAIL contention_we%0d: got we=%b rd=%0d", i, we, rd);
        end
      end
      tick();
    end
    a_valid = 0; b_valid = 0; #1;
    checks++; if (we !== 1'b1 || rd !== 5'd2 || wd !== mwd) begin errors++; $display("FAIL contention_last: got we=%b rd=%0d wd=%h want 1/2/%h", we, rd, wd, mwd); end
    tick();
  endtask

  task automatic test_scoreboard();
    rs1 = 7; rs2 = 0; iss_valid = 1; iss_rd = 7; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_pre_issue: got %b want 0", stall); end
    tick(); iss_valid = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_after_issue: got %b want 1", stall); end
    tick();
    b_valid = 1; b_rd = 7; b_wd = $urandom; #1;
    checks++; if (b_ready !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_b_xfer: got ready=%b stall=%b want 1/1", b_ready, stall); end
    tick(); b_valid = 0; #1;
    checks++; if (we !== 1'b1 || rd !== 5'd7 || stall !== 1'b1) begin errors++; $display("FAIL sb_we_cycle: got we=%b rd=%0d stall=%b want 1/7/1", we, rd, stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b want 0", stall); end
    // Issue lands on the very edge that retires a write to the same register.
    b_valid = 1; b_rd = 7; b_wd = $urandom; #1;
    tick(); b_valid = 0; iss_valid = 1; iss_rd = 7; #1;
    checks++; if (we !== 1'b1 || rd !== 5'd7) begin errors++; $display("FAIL sb_same_we: got we=%b rd=%0d want 1/7", we, rd); end
    tick(); iss_valid = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", stall); end
    rs1 = 0; rs2 = 7; tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_rs2: got %b want 1", stall); end
    a_valid = 1; a_rd = 7; a_wd = $urandom; #1; tick(); a_valid = 0; tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_final_clear: got %b want 0", stall); end
    rs2 = 0;
  endtask

  task automatic test_x0();
    a_valid = 1; a_rd = 0; a_wd = 32'h1234; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", a_ready); end
    tick(); a_valid = 0; #1;
    checks++; if (we !== 1'b0 || rd !== 5'd0 || wd !== 32'h1234) begin errors++; $display("FAIL x0_port: got we=%b rd=%0d wd=%h want 0/0/1234", we, rd, wd); end
    iss_valid = 1; iss_rd = 0; rs1 = 0; rs2 = 0;
    tick(); iss_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1; checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall%0d: got %b want 0", i, stall); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    iss_valid = 1; iss_rd = 11; a_valid = 1; a_rd = 9; a_wd = $urandom; #1;
    tick(); iss_valid = 0; a_valid = 0; rs1 = 11; #1;
    checks++; if (we !== 1'b1 || rd !== 5'd9 || stall !== 1'b1) begin errors++; $display("FAIL ar_before: got we=%b rd=%0d stall=%b want 1/9/1", we, rd, stall); end
    #1; rst_n = 0; a_valid = 1; b_valid = 1; #1;
    checks++; if (we !== 1'b0 || rd !== 5'd0 || wd !== 32'd0) begin errors++; $display("FAIL ar_port: got we=%b rd=%0d wd=%h want 0/0/0", we, rd, wd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", stall); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL ar_ready: got %b%b want 00", a_ready, b_ready); end
    model_reset();
    @(negedge clk); rst_n = 1; a_rd = 1; b_rd = 2; #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL ar_first_tie: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    tick(); #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL ar_second_tie: got a=%b b=%b want b=1", a_ready, b_ready); end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_random(input int n);
    bit ga, gb, a_hold, b_hold;
    int unsigned r;
    a_hold = 0; b_hold = 0;
    for (int i = 0; i < n; i++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 2) != 0); a_rd = 5'($urandom_range(0, 7)); a_wd = $urandom;
      end
      if (!b_hold) begin
        b_valid = ($urandom_range(0, 2) != 0); b_rd = 5'($urandom_range(0, 7)); b_wd = $urandom;
      end
      r = $urandom_range(0, 7);
      iss_rd = 5'(r);
      iss_valid = ($urandom_range(0, 2) == 0) && (r == 0 || !mbusy[r]);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      #1;
      model_grant(ga, gb);
      checks++;
      if (a_ready !== ga || b_ready !== gb) begin
        errors++; $display("FAIL rand_grant%0d: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, ga, gb);
      end
      checks++;
      if (stall !== exp_stall()) begin
        errors++; $display("FAIL rand_stall%0d: got %b want %b (rs1=%0d rs2=%0d)", i, stall, exp_stall(), rs1, rs2);
      end
      checks++;
      if (we !== mwe || rd !== mrd || wd !== mwd) begin
        errors++; $display("FAIL rand_port%0d: got %b/%0d/%h want %b/%0d/%h", i, we, rd, wd, mwe, mrd, mwd);
      end
      a_hold = a_valid && !ga;
      b_hold = b_valid && !gb;
      tick();
    end
    idle_inputs(); tick(); tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    model_reset();
    test_reset();
    test_a_only();
    test_contention();
    test_scoreboard();
    test_x0();
    test_async_reset();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
